// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: round-robin grant, one
// operation in flight, result held until the owning requester consumes it.
//
// state | meaning
// IDLE  | no operation in flight; ready offered to the selected requester
// BUSY  | operands driven to the ALU, latency counter running down
// RESP  | result captured and held for the granted requester
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_rs,
    input  logic [31:0] req0_rt,
    input  logic [31:0] req1_rs,
    input  logic [31:0] req1_rt,
    input  logic [4:0]  req0_shamt,
    input  logic [4:0]  req1_shamt,
    input  logic [3:0]  req0_ALUControl,
    input  logic [3:0]  req1_ALUControl,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rt,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_ALUControl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       cur;
    logic       sel;
    logic       accept;
    logic       rsp_take;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid)
            sel = ~last_grant;
        else if (req1_valid)
            sel = 1'b1;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !sel;
    assign req1_ready = (state == IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;
    assign rsp_take   = cur ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            last_grant     <= 1'b1;
            cur            <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp_result     <= 32'd0;
            rsp_zero       <= 1'b0;
            alu_rs         <= 32'd0;
            alu_rt         <= 32'd0;
            alu_shamt      <= 5'd0;
            alu_ALUControl <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_rs         <= sel ? req1_rs : req0_rs;
                        alu_rt         <= sel ? req1_rt : req0_rt;
                        alu_shamt      <= sel ? req1_shamt : req0_shamt;
                        alu_ALUControl <= sel ? req1_ALUControl : req0_ALUControl;
                        cnt            <= LAT_M1;
                        last_grant     <= sel;
                        cur            <= sel;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp0_valid <= !cur;
                        rsp1_valid <= cur;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
